// File: rtl/div_if.sv
// Request/response bundle between the EX stage (master) and the multi-cycle divider (slave).
interface div_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_unit.sv
// Restoring shift-subtract divider producing {remainder, quotient} for DIV/DIVU.
// Optional DIV_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {
    S_FREE  = 2'd0,
    S_DZERO = 2'd1,
    S_ON    = 2'd2,
    S_END   = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;
  logic               r_sign1;
  logic               r_sign2;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_busy;

  logic               w_sign1;
  logic               w_sign2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_quo_nx;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quo_fix;

  function automatic logic [WIDTH-1:0] f_neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign w_sign1 = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign w_sign2 = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign w_mag1  = f_neg_if(bus.opdata1_i, w_sign1);
  assign w_mag2  = f_neg_if(bus.opdata2_i, w_sign2);

  // One restoring step; the extra top bit keeps the trial subtraction overflow-free.
  always_comb begin
    w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_div};
    if (!w_diff[WIDTH]) begin
      w_rem_nx = w_diff[WIDTH-1:0];
      w_quo_nx = {r_quo[WIDTH-2:0], 1'b1};
    end else begin
      w_rem_nx = w_rem_sh[WIDTH-1:0];
      w_quo_nx = {r_quo[WIDTH-2:0], 1'b0};
    end
  end

  // Signs were latched already qualified by signedness, so DIVU never fixes up.
  assign w_quo_fix = f_neg_if(w_quo_nx, r_sign1 ^ r_sign2);
  assign w_rem_fix = f_neg_if(w_rem_nx, r_sign1);

  // Divider FSM with registered result/ready/busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FREE;
      r_cnt    <= {CNT_W{1'b0}};
      r_rem    <= {WIDTH{1'b0}};
      r_quo    <= {WIDTH{1'b0}};
      r_div    <= {WIDTH{1'b0}};
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_result <= {(2*WIDTH){1'b0}};
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == {WIDTH{1'b0}}) begin
              r_state <= S_DZERO;
              r_busy  <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            end else if (w_mag1 < w_mag2) begin
              r_state  <= S_END;
              r_ready  <= 1'b1;
              r_result <= {bus.opdata1_i, {WIDTH{1'b0}}};
`endif
            end else begin
              r_state <= S_ON;
              r_busy  <= 1'b1;
              r_cnt   <= {CNT_W{1'b0}};
              r_rem   <= {WIDTH{1'b0}};
              r_quo   <= w_mag1;
              r_div   <= w_mag2;
              r_sign1 <= w_sign1;
              r_sign2 <= w_sign2;
            end
          end
        end
        S_DZERO: begin
          r_busy <= 1'b0;
          if (bus.annul_i) begin
            r_state <= S_FREE;
          end else begin
            r_state  <= S_END;
            r_ready  <= 1'b1;
            r_result <= {(2*WIDTH){1'b0}};
          end
        end
        S_ON: begin
          if (bus.annul_i) begin
            r_state <= S_FREE;
            r_busy  <= 1'b0;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH-1)) begin
              r_state  <= S_END;
              r_busy   <= 1'b0;
              r_ready  <= 1'b1;
              r_result <= {w_rem_fix, w_quo_fix};
            end
          end
        end
        S_END: begin
          if (!bus.start_i || bus.annul_i) begin
            r_state  <= S_FREE;
            r_ready  <= 1'b0;
            r_result <= {(2*WIDTH){1'b0}};
          end
        end
        default: begin
          r_state  <= S_FREE;
          r_busy   <= 1'b0;
          r_ready  <= 1'b0;
          r_result <= {(2*WIDTH){1'b0}};
        end
      endcase
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;
  assign bus.busy_o   = r_busy;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (DIV/DIVU, divide-by-zero, annul, reset).
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32), .CNT_W(6)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_SMALL = 33;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one division with start held, check latency, result, hold and release.
  task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int          lat;
    logic [63:0] res;
    lat = 0;
    bus.signed_div_i = sg;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    for (int i = 1; i <= 50 && lat == 0; i++) begin
      tick();
      if (i == 1) begin
        bus.opdata1_i    = ~a;
        bus.opdata2_i    = ~b;
        bus.signed_div_i = ~sg;
        if (exp_lat > 1) chk({tag, " busy"}, {63'd0, bus.busy_o}, 64'd1);
      end
      if (bus.ready_o) lat = i;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " lo"}, {32'd0, bus.result_o[31:0]}, {32'd0, exp_lo});
    chk({tag, " hi"}, {32'd0, bus.result_o[63:32]}, {32'd0, exp_hi});
    res = bus.result_o;
    tick();
    chk({tag, " hold ready"}, {63'd0, bus.ready_o}, 64'd1);
    chk({tag, " hold result"}, bus.result_o, res);
    bus.start_i = 1'b0;
    tick();
    chk({tag, " release ready"}, {63'd0, bus.ready_o}, 64'd0);
    chk({tag, " release result"}, bus.result_o, 64'd0);
    chk({tag, " release busy"}, {63'd0, bus.busy_o}, 64'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    tick();
    tick();
    chk("reset result", bus.result_o, 64'd0);
    chk("reset ready", {63'd0, bus.ready_o}, 64'd0);
    chk("reset busy", {63'd0, bus.busy_o}, 64'd0);
    rst = 1'b0;
    tick();

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
    run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
    run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0);
    run_div("divu max/max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'd1, 32'd0);
    run_div("divu x/0", 1'b0, 32'd1234, 32'd0, 2, 32'd0, 32'd0);
    run_div("div x/0", 1'b1, 32'hFFFF_FF00, 32'd0, 2, 32'd0, 32'd0);
    run_div("divu 5/9", 1'b0, 32'd5, 32'd9, LAT_SMALL, 32'd0, 32'd5);
    run_div("div -5/9", 1'b1, 32'hFFFF_FFFB, 32'd9, LAT_SMALL, 32'd0, 32'hFFFF_FFFB);
    run_div("divu 0/5", 1'b0, 32'd0, 32'd5, LAT_SMALL, 32'd0, 32'd0);

    // Annul mid-division, then a fresh request must work.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    tick();
    chk("annul busy", {63'd0, bus.busy_o}, 64'd0);
    chk("annul ready", {63'd0, bus.ready_o}, 64'd0);
    bus.annul_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("annul no ready", {63'd0, bus.ready_o}, 64'd0);
    end
    run_div("divu 9/3", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0);

    // Annul blocks a start in FREE.
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    tick();
    chk("annul free busy", {63'd0, bus.busy_o}, 64'd0);
    tick();
    chk("annul free ready", {63'd0, bus.ready_o}, 64'd0);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    tick();

    // Annul while in DZERO.
    bus.opdata1_i = 32'd5;
    bus.opdata2_i = 32'd0;
    bus.start_i   = 1'b1;
    tick();
    chk("dzero busy", {63'd0, bus.busy_o}, 64'd1);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    tick();
    chk("dzero annul ready", {63'd0, bus.ready_o}, 64'd0);
    chk("dzero annul busy", {63'd0, bus.busy_o}, 64'd0);
    bus.annul_i = 1'b0;
    tick();

    // Reset mid-division.
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    for (int i = 0; i < 21; i++) tick();
    chk("pre-reset busy", {63'd0, bus.busy_o}, 64'd1);
    rst         = 1'b1;
    bus.start_i = 1'b0;
    tick();
    chk("midreset result", bus.result_o, 64'd0);
    chk("midreset ready", {63'd0, bus.ready_o}, 64'd0);
    chk("midreset busy", {63'd0, bus.busy_o}, 64'd0);
    rst = 1'b0;
    tick();
    run_div("divu 100/10", 1'b0, 32'd100, 32'd10, 33, 32'd10, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the EX stage. Serves DIV/DIVU.
- Produces the {hi, lo} pair (remainder, quotient) that EX forwards as its HI/LO write with the HI/LO write enable asserted. This is the data source of the HI/LO path that the EX/MEM register carries downstream.
- EX holds the pipeline while a division is in flight, using start/ready.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- opdata1_i  in  WIDTH  dividend; sampled with start
- opdata2_i  in  WIDTH  divisor; sampled with start
- start_i  in  1  request; EX holds it high until it sees ready_o
- annul_i  in  1  abort in-flight division (flush/exception)
- result_o  out  2*WIDTH  [2W-1:W] = remainder (hi), [W-1:0] = quotient (lo)
- ready_o  out  1  result_o valid
- busy_o  out  1  high in DZERO/ON; EX uses it as its stall request

Behaviour:
- Reset: state=FREE, cnt=0, result_o=0, ready_o=0, busy_o=0. Reset overrides everything, including mid-division; no partial result is ever visible.
- States: FREE, DZERO, ON, END.
- FREE:
  - Samples start_i && !annul_i only in FREE.
  - Divisor==0: go to DZERO.
  - Otherwise: latch operand magnitudes (two's-complement negate when signed and negative), latch both operand signs, clear the partial remainder, set cnt=0, go to ON.
- DZERO: next edge goes to END with result_o=0 and ready_o=1.
- ON:
  - Restoring shift-subtract, one quotient bit per edge, MSB first.
  - Shift {rem, dividend} left by 1.
  - If rem_shifted >= divisor: subtract divisor and shift in 1; else shift in 0.
  - The subtraction is computed WIDTH+1 bits wide, so no overflow is possible.
  - After the iteration where cnt==WIDTH-1, go to END.
- Sign fixup, applied on entry to END when signed:
  - Quotient negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0 (wrap, no trap).
- Latency, counted from the edge that samples start:
  - Nonzero divisor: ready_o=1 visible after WIDTH+1 = 33 edges.
  - Zero divisor: ready_o=1 after 2 edges.
- END:
  - ready_o=1 and result_o are held stable while start_i=1.
  - When start_i=0 (and on annul_i), next edge goes to FREE with ready_o=0 and result_o=0.
- annul_i:
  - In DZERO/ON: next edge goes to FREE, ready_o stays 0, result discarded.
  - In FREE: blocks the start.
  - annul_i takes priority over start_i.
- Operand changes after the start edge are ignored; values are latched.
- busy_o = (state==DZERO || state==ON).

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in FREE, if divisor != 0 and |dividend| < |divisor| (unsigned magnitude compare), go straight to END at the next edge. Output is quotient=0 and remainder=original dividend (sign preserved); ready_o is visible after 1 edge. Dividend==0 with nonzero divisor takes this path.
- Undefined: such operands take the full 33-edge ON path. Results are identical, only latency differs.

Test Plan:
- DIVU 100/7, start held -> ready_o rises exactly 33 edges after start edge; result_o[31:0]=14, [63:32]=2; start dropped -> ready_o=0, result_o=0 next edge.
- DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
- Divisor 0 (either signedness) -> busy_o 1 cycle, ready_o after 2 edges, result_o=0.
- annul_i pulsed at iteration 10 -> FREE next edge, ready_o never asserts; new DIVU 9/3 then gives lo=3, hi=0. rst asserted at iteration 20 -> all outputs 0 next edge.
- DIVU 5/9: with DIV_EARLY_OUT_EN -> ready after 1 edge, lo=0, hi=5; without -> ready after 33 edges, same result.
